// File: rtl/tty_uart_tx.sv
// Buffered 8N1 UART transmitter for the MCU TTY port: a FIFO absorbs write bursts and a
// baud-timed FSM serialises {1'b0, char} LSB first; writes into a full FIFO set a sticky ovf_o.
module tty_uart_tx #(
  parameter int CLKS_PER_BIT = 21,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic [6:0] tty_i,
  input  logic       tty_we_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       full_o,
  output logic       ovf_o
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [6:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW:0]   count;
  logic [15:0]        baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               baud_tc;
  logic               fifo_nonempty;
  logic               pop;
  logic               push;

  assign baud_tc       = (baud == BAUD_LAST);
  assign fifo_nonempty = (count != '0);
  // Pop either from idle or on the last stop-bit cycle, so queued frames run back to back.
  assign pop  = fifo_nonempty && ((state == IDLE) || ((state == STOP) && baud_tc));
  assign push = tty_we_i && ((count != DEPTH_C) || pop);

  assign busy_o = (state != IDLE) || fifo_nonempty;
  assign full_o = (count == DEPTH_C);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= tty_i;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (tty_we_i && !push) ovf_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= {1'b0, mem[rd_ptr]};
            baud  <= '0;
            state <= START;
            tx_o  <= 1'b0;
          end
        end
        START: begin
          if (baud_tc) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_o    <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud    <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            // tx_o is loaded with the bit about to go out, keeping the line purely registered.
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_o  <= 1'b1;
            end else begin
              tx_o <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud <= '0;
            if (pop) begin
              shift <= {1'b0, mem[rd_ptr]};
              state <= START;
              tx_o  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_o  <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/tty_uart_tx.md
# tty_uart_tx

Buffered UART transmitter that consumes the MCU's TTY character stream (7-bit character plus one-cycle write strobe, produced by the bus decoder on a store to the TTY address) and serialises it onto a single 8N1 serial line. It sits directly downstream of the MCU top level, in the board wrapper. A small FIFO absorbs bursts of back-to-back stores from the single-cycle core, so software never stalls.

## Interface
Parameters:
- CLKS_PER_BIT, 21, clock cycles per serial bit (2.4 MHz / 115200 ≈ 21); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries of 7 bits.

Ports:
- clk_i  in  1  system clock (same domain as the MCU core); all state updates on the rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- tty_i  in  7  character from the MCU TTY port.
- tty_we_i  in  1  write strobe; each high cycle is one character.
- tx_o  out  1  serial line, idle high.
- busy_o  out  1  high while a frame is on the line or the FIFO is non-empty.
- full_o  out  1  FIFO holds 2**FIFO_AW entries.
- ovf_o  out  1  sticky: a write was dropped. Cleared only by reset.

## Operation
- Reset values: tx_o=1, busy_o=0, full_o=0, ovf_o=0, FIFO empty, FSM in IDLE, bit counter and baud counter 0.
- FIFO:
  - Circular buffer with read and write pointers of FIFO_AW bits that wrap modulo depth.
  - Count register of FIFO_AW+1 bits.
  - A write is accepted when tty_we_i=1 and either count < depth or a pop happens in the same cycle.
  - Otherwise the write is dropped and ovf_o is set on that edge.
  - Simultaneous push and pop leaves count unchanged.
- Frame format: start bit (0), 8 data bits LSB first ({1'b0, char}, so bit 7 is always 0), stop bit (1).
- FSM states and transitions:
  - IDLE: tx_o=1. If the FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for CLKS_PER_BIT cycles. Then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. Then:
    - if the FIFO is non-empty: pop and go directly to START (no extra idle cycle);
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. The terminal count advances the FSM and reloads the counter to 0.
- tx_o is driven from a register (glitch-free).
- busy_o = (state != IDLE) | (count != 0), registered-equivalent (derived from registered state only).
- full_o = (count == depth).

## Timing
- Write accepted at edge k (FIFO was empty, FSM in IDLE):
  - IDLE pops at edge k+1, and the FSM enters START.
  - tx_o is first 0 in the cycle after edge k+1, i.e. 2 cycles of latency from the strobe.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames from a non-empty FIFO are contiguous: the stop bit is followed immediately by the next start bit.
- busy_o rises the cycle after the first accepted write. It falls the cycle after the last stop bit ends with the FIFO empty.
- Strobe held high for N cycles enqueues N copies of tty_i, sampled on each edge.
- Asynchronous reset mid-frame:
  - tx_o returns to 1 immediately and the FIFO is flushed.
  - The receiver sees a truncated frame, which is accepted behaviour.
- ovf_o once set stays set through all further traffic until rst_in is asserted.

## Test plan
- Reset: assert rst_in=0 mid-simulation with no clock edge -> tx_o=1, busy_o=0, full_o=0, ovf_o=0 immediately.
- Single char (CLKS_PER_BIT=4): one-cycle write of 7'h41 -> tx_o low from 2 cycles after the strobe, then the bit sequence 0,1,0,0,0,0,0,1,0,1, each held 4 cycles (40 cycles total); busy_o falls 1 cycle after.
- Burst: 3 writes on consecutive cycles of 7'h48, 7'h69, 7'h21 -> three contiguous frames, 120 cycles total at CLKS_PER_BIT=4, no idle gap, correct order.
- Full/overflow (FIFO_AW=2):
  - 6 consecutive writes while the first frame is starting -> the first is popped, the next 4 fill the FIFO, and full_o=1.
  - The 6th write is dropped: ovf_o=1 and stays 1.
  - Exactly 5 frames are transmitted.
- Push while full at the STOP→START pop edge: a write on that exact cycle is accepted, count stays at depth, and ovf_o stays 0.
- Reset mid-frame: rst_in low during DATA bit 3 -> tx_o=1 at once. After release, a new write of 7'h55 transmits a clean, complete frame.
